// File: rtl/accumulator_unit_pkg.sv
// Purpose: shared state encoding and widths for accumulator_unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package accumulator_unit_pkg;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/accumulator_unit_adder.sv
// Purpose: 8-bit ripple-carry adder, out = in1 + in2 mod 256 (no carry-out port).
// Latency: purely combinational.
// Backpressure: none.
// Ports: in1, in2 - operands; out - wrapped sum.
module adder (
   input  logic [7:0] in1,
   input  logic [7:0] in2,
   output logic [7:0] out
);

   logic [7:0] carry;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < 8; i++) begin : g_bit
      assign out[i] = in1[i] ^ in2[i] ^ carry[i];
      // The carry out of bit 7 is deliberately not produced.
      if (i < 7) begin : g_carry
         assign carry[i+1] = (in1[i] & in2[i]) | (carry[i] & (in1[i] ^ in2[i]));
      end
   end

endmodule

// File: rtl/accumulator_unit.sv
// Purpose: sums N_SAMPLES unsigned 8-bit samples through one adder, reports wrapped total + sticky carry flag.
// Latency: out_valid rises the cycle after the last sample is accepted; start costs one cycle.
// Backpressure: in_ready only in ACCUM; result held in DONE until out_ready.
// Ports: clk/rst (sync, active-high); start; in_data/in_valid/in_ready sample stream;
//        sum_out/overflow/out_valid/out_ready result stream; busy high in ACCUM or DONE.
module accumulator_unit #(
   parameter int N_SAMPLES = 4,
   parameter int DATA_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] sum_out,
   output logic              overflow,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   import accumulator_unit_pkg::*;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

   state_t            state;
   state_t            state_nx;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] new_sum;
   logic [CNT_W-1:0]  cnt;
   logic              accept;
   logic              last;
   logic              carry;

   adder u_adder (
      .in1 (acc),
      .in2 (in_data),
      .out (new_sum)
   );

   // The adder has no carry-out; a wrapped result is always smaller than acc.
   assign carry  = (new_sum < acc);
   assign accept = in_valid && in_ready;
   assign last   = (cnt == LAST_IDX);

   // Moore outputs decoded from state.
   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = ACCUM;
            end
         end
         ACCUM: begin
            if (accept && last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            // start in the transfer cycle is dropped; it must be re-presented in IDLE.
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         cnt      <= '0;
         sum_out  <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc      <= '0;
                  cnt      <= '0;
                  overflow <= 1'b0;
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc      <= new_sum;
                  cnt      <= cnt + 1'b1;
                  overflow <= overflow | carry;
                  if (last) begin
                     sum_out <= new_sum;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_accumulator_unit.sv
module tb_accumulator_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, in_valid, out_ready;
   logic [7:0] in_data;
   logic       in_ready, overflow, out_valid, busy;
   logic [7:0] sum_out;

   logic       start_1, in_valid_1, out_ready_1;
   logic [7:0] in_data_1;
   logic       in_ready_1, overflow_1, out_valid_1, busy_1;
   logic [7:0] sum_out_1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   accumulator_unit #(.N_SAMPLES(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .sum_out(sum_out), .overflow(overflow),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
   );

   accumulator_unit #(.N_SAMPLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start_1), .in_data(in_data_1), .in_valid(in_valid_1),
      .in_ready(in_ready_1), .sum_out(sum_out_1), .overflow(overflow_1),
      .out_valid(out_valid_1), .out_ready(out_ready_1), .busy(busy_1)
   );

   typedef struct {
      logic [3:0][7:0] s;
      bit              stall;
      int              hold;
      int              exp_sum;
      int              exp_ovf;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run4(input vec_t v, input string tag);
      int accepts;
      accepts = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, " in_ready after start"}, int'(in_ready), 1);
      chk({tag, " busy after start"}, int'(busy), 1);
      chk({tag, " overflow cleared"}, int'(overflow), 0);
      for (int i = 0; i < 4; i++) begin
         if (v.stall) begin
            in_valid = 1'b0;
            in_data  = 8'hFF;
            step();
            chk({tag, " stall out_valid"}, int'(out_valid), 0);
            chk({tag, " stall in_ready"}, int'(in_ready), 1);
         end
         in_valid = 1'b1;
         in_data  = v.s[i];
         if (in_ready) accepts++;
         step();
         in_valid = 1'b0;
         chk({tag, " out_valid timing"}, int'(out_valid), (i == 3) ? 1 : 0);
      end
      chk({tag, " accept count"}, accepts, 4);
      chk({tag, " sum_out"}, int'(sum_out), v.exp_sum);
      chk({tag, " overflow"}, int'(overflow), v.exp_ovf);
      chk({tag, " busy in DONE"}, int'(busy), 1);
      chk({tag, " in_ready in DONE"}, int'(in_ready), 0);
      for (int h = 0; h < v.hold; h++) begin
         start = (h % 2 == 0);
         step();
         chk({tag, " held out_valid"}, int'(out_valid), 1);
         chk({tag, " held sum_out"}, int'(sum_out), v.exp_sum);
         chk({tag, " held overflow"}, int'(overflow), v.exp_ovf);
         chk({tag, " held in_ready"}, int'(in_ready), 0);
      end
      out_ready = 1'b1;
      start     = 1'b1;
      step();
      out_ready = 1'b0;
      start     = 1'b0;
      chk({tag, " out_valid after xfer"}, int'(out_valid), 0);
      chk({tag, " busy after xfer"}, int'(busy), 0);
      chk({tag, " sum_out retained"}, int'(sum_out), v.exp_sum);
      step();
      chk({tag, " no restart from xfer start"}, int'(busy), 0);
   endtask

   initial begin
      vec_t v;
      vecs[0] = '{s: {8'd40, 8'd30, 8'd20, 8'd10},    stall: 1'b0, hold: 5, exp_sum: 100, exp_ovf: 0};
      vecs[1] = '{s: {8'd1, 8'd1, 8'd100, 8'd200},    stall: 1'b0, hold: 2, exp_sum: 46,  exp_ovf: 1};
      vecs[2] = '{s: {8'd8, 8'd7, 8'd6, 8'd5},        stall: 1'b1, hold: 0, exp_sum: 26,  exp_ovf: 0};
      vecs[3] = '{s: {8'd0, 8'd0, 8'd0, 8'd0},        stall: 1'b0, hold: 1, exp_sum: 0,   exp_ovf: 0};
      vecs[4] = '{s: {8'd0, 8'd0, 8'd1, 8'd255},      stall: 1'b1, hold: 1, exp_sum: 0,   exp_ovf: 1};
      vecs[5] = '{s: {8'd0, 8'd3, 8'd255, 8'd255},    stall: 1'b0, hold: 3, exp_sum: 1,   exp_ovf: 1};

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
      start_1 = 1'b0; in_valid_1 = 1'b0; in_data_1 = 8'd0; out_ready_1 = 1'b0;
      step();
      step();
      chk("reset sum_out", int'(sum_out), 0);
      chk("reset overflow", int'(overflow), 0);
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset in_ready", int'(in_ready), 0);
      chk("reset busy", int'(busy), 0);

      // rst together with start: rst wins
      start = 1'b1;
      step();
      chk("rst+start busy", int'(busy), 0);
      rst   = 1'b0;
      start = 1'b0;
      step();
      chk("idle holds busy", int'(busy), 0);
      chk("idle in_ready", int'(in_ready), 0);

      for (int k = 0; k < 6; k++) begin
         run4(vecs[k], $sformatf("vec%0d", k));
      end

      // reset mid-run after two samples
      start = 1'b1;
      step();
      start = 1'b0;
      in_valid = 1'b1; in_data = 8'd10;
      step();
      in_data = 8'd20;
      step();
      in_valid = 1'b0;
      chk("midrun busy before rst", int'(busy), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrun rst sum_out", int'(sum_out), 0);
      chk("midrun rst overflow", int'(overflow), 0);
      chk("midrun rst out_valid", int'(out_valid), 0);
      chk("midrun rst in_ready", int'(in_ready), 0);
      chk("midrun rst busy", int'(busy), 0);
      v = '{s: {8'd4, 8'd3, 8'd2, 8'd1}, stall: 1'b0, hold: 0, exp_sum: 10, exp_ovf: 0};
      run4(v, "post_rst");

      // N_SAMPLES=1 instance
      start_1 = 1'b1;
      step();
      start_1 = 1'b0;
      chk("n1 in_ready", int'(in_ready_1), 1);
      in_valid_1 = 1'b1; in_data_1 = 8'd255;
      step();
      in_valid_1 = 1'b0;
      chk("n1 out_valid", int'(out_valid_1), 1);
      chk("n1 sum 255", int'(sum_out_1), 255);
      chk("n1 ovf 255", int'(overflow_1), 0);
      out_ready_1 = 1'b1;
      step();
      out_ready_1 = 1'b0;
      chk("n1 idle after xfer", int'(busy_1), 0);
      start_1 = 1'b1;
      step();
      for (int j = 0; j < 2; j++) begin
         step();
         chk("n1 start in ACCUM busy", int'(busy_1), 1);
         chk("n1 start in ACCUM in_ready", int'(in_ready_1), 1);
         chk("n1 start in ACCUM out_valid", int'(out_valid_1), 0);
      end
      start_1 = 1'b0;
      in_valid_1 = 1'b1; in_data_1 = 8'd0;
      step();
      in_valid_1 = 1'b0;
      chk("n1 out_valid zero", int'(out_valid_1), 1);
      chk("n1 sum 0", int'(sum_out_1), 0);
      chk("n1 ovf 0", int'(overflow_1), 0);
      out_ready_1 = 1'b1;
      step();
      out_ready_1 = 1'b0;
      chk("n1 final idle", int'(out_valid_1), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
